// File: rtl/or1200_opmux_pkg.sv
// Shared select-code constants and helpers for the generic operand mux.
package or1200_opmux_pkg;

    localparam int unsigned SEL_RF       = 0;
    localparam int unsigned SEL_IMM      = 1;
    localparam int unsigned SEL_FWD_BASE = 2;

    // Codes cover RF, IMM and every forwarding source.
    function automatic int unsigned sel_width(input int unsigned num_fwd);
        return $clog2(num_fwd + SEL_FWD_BASE);
    endfunction

    // Callers must qualify the result with code >= SEL_FWD_BASE.
    function automatic int unsigned fwd_index(input int unsigned code);
        return code - SEL_FWD_BASE;
    endfunction

endpackage

// File: rtl/or1200_opmux_chan.sv
// One operand channel: source select mux plus the capture/saved register toward EX.
module or1200_opmux_chan
    import or1200_opmux_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned SEL_W   = sel_width(NUM_FWD),
    parameter bit          IMM_EN  = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_freeze,
    input  logic                     ex_freeze,
    input  logic                     flush,
    input  logic                     hazard_hold,
    input  logic [WIDTH-1:0]         rf_data,
    input  logic [WIDTH-1:0]         imm,
    input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         muxed,
    output logic                     fwd_hit,
    output logic [WIDTH-1:0]         operand,
    output logic                     saved
);

    logic [WIDTH-1:0] operand_q, operand_d;
    logic             saved_q, saved_d;
    int unsigned      sel_int;

    assign sel_int = 32'(sel);

    always_comb begin
        muxed   = rf_data;
        fwd_hit = 1'b0;
        if (sel_int == SEL_RF) begin
            muxed = rf_data;
        end else if (sel_int == SEL_IMM) begin
            if (IMM_EN) begin
                muxed = imm;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_FWD; k++) begin
                if (fwd_index(sel_int) == k) begin
                    muxed   = fwd_data[k*WIDTH +: WIDTH];
                    fwd_hit = !fwd_valid[k];
                end
            end
        end
    end

    // A saved operand survives an ID freeze; the first unfrozen cycle only releases it.
    always_comb begin
        operand_d = operand_q;
        saved_d   = saved_q;
        if (flush) begin
            operand_d = '0;
            saved_d   = 1'b0;
        end else if (!ex_freeze && !hazard_hold) begin
            if (!saved_q) begin
                operand_d = muxed;
                saved_d   = id_freeze;
            end else if (!id_freeze) begin
                saved_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            operand_q <= '0;
            saved_q   <= 1'b0;
        end else begin
            operand_q <= operand_d;
            saved_q   <= saved_d;
        end
    end

    assign operand = operand_q;
    assign saved   = saved_q;

endmodule

// File: rtl/or1200_operandmux_gen.sv
// ID/EX operand selection for NUM_OPS channels with forwarding, load-use stall and hazard count.
module or1200_operandmux_gen
    import or1200_opmux_pkg::*;
#(
    parameter int unsigned         WIDTH    = 32,
    parameter int unsigned         NUM_OPS  = 2,
    parameter int unsigned         NUM_FWD  = 2,
    parameter logic [NUM_OPS-1:0]  IMM_MASK = 2'b10,
    parameter int unsigned         SEL_W    = sel_width(NUM_FWD),
    parameter int unsigned         CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_freeze,
    input  logic                     ex_freeze,
    input  logic                     flush,
    input  logic [NUM_OPS*WIDTH-1:0] rf_data,
    input  logic [WIDTH-1:0]         imm,
    input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [NUM_OPS*SEL_W-1:0] sel,
    output logic [NUM_OPS*WIDTH-1:0] muxed,
    output logic [NUM_OPS*WIDTH-1:0] operand,
    output logic [NUM_OPS-1:0]       saved,
    output logic                     hazard_stall,
    output logic [CNT_W-1:0]         hazard_cnt
);

    logic [NUM_OPS-1:0] fwd_hit;
    logic [CNT_W-1:0]   hazard_cnt_q, hazard_cnt_d;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_chan
        or1200_opmux_chan #(
            .WIDTH   (WIDTH),
            .NUM_FWD (NUM_FWD),
            .SEL_W   (SEL_W),
            .IMM_EN  (IMM_MASK[i])
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .id_freeze   (id_freeze),
            .ex_freeze   (ex_freeze),
            .flush       (flush),
            .hazard_hold (hazard_stall),
            .rf_data     (rf_data[i*WIDTH +: WIDTH]),
            .imm         (imm),
            .fwd_data    (fwd_data),
            .fwd_valid   (fwd_valid),
            .sel         (sel[i*SEL_W +: SEL_W]),
            .muxed       (muxed[i*WIDTH +: WIDTH]),
            .fwd_hit     (fwd_hit[i]),
            .operand     (operand[i*WIDTH +: WIDTH]),
            .saved       (saved[i])
        );
    end

    // One stall freezes every channel so captured operands stay coherent.
    assign hazard_stall = (|fwd_hit) && !ex_freeze;

    always_comb begin
        hazard_cnt_d = hazard_cnt_q;
        if (hazard_stall && (hazard_cnt_q != '1)) begin
            hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hazard_cnt_q <= '0;
        end else begin
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_or1200_operandmux_gen.sv
// Directed bench for or1200_operandmux_gen: default instance plus a 3-source, 4-bit-counter one.
module tb_or1200_operandmux_gen;

    logic        clk = 1'b0;
    logic        rst, id_freeze, ex_freeze, flush;
    logic [63:0] rf_data;
    logic [31:0] imm;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_valid;
    logic [3:0]  sel;
    logic [63:0] muxed, operand;
    logic [1:0]  saved;
    logic        hazard_stall;
    logic [15:0] hazard_cnt;

    logic [95:0] fwd_data_s;
    logic [2:0]  fwd_valid_s;
    logic [5:0]  sel_s;
    logic [63:0] muxed_s, operand_s;
    logic [1:0]  saved_s;
    logic        hazard_stall_s;
    logic [3:0]  hazard_cnt_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    or1200_operandmux_gen dut (
        .clk          (clk),
        .rst          (rst),
        .id_freeze    (id_freeze),
        .ex_freeze    (ex_freeze),
        .flush        (flush),
        .rf_data      (rf_data),
        .imm          (imm),
        .fwd_data     (fwd_data),
        .fwd_valid    (fwd_valid),
        .sel          (sel),
        .muxed        (muxed),
        .operand      (operand),
        .saved        (saved),
        .hazard_stall (hazard_stall),
        .hazard_cnt   (hazard_cnt)
    );

    or1200_operandmux_gen #(
        .NUM_FWD (3),
        .CNT_W   (4)
    ) dut_s (
        .clk          (clk),
        .rst          (rst),
        .id_freeze    (id_freeze),
        .ex_freeze    (ex_freeze),
        .flush        (flush),
        .rf_data      (rf_data),
        .imm          (imm),
        .fwd_data     (fwd_data_s),
        .fwd_valid    (fwd_valid_s),
        .sel          (sel_s),
        .muxed        (muxed_s),
        .operand      (operand_s),
        .saved        (saved_s),
        .hazard_stall (hazard_stall_s),
        .hazard_cnt   (hazard_cnt_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; id_freeze = 1'b0; ex_freeze = 1'b0; flush = 1'b0;
        rf_data = {32'h22, 32'h11}; imm = 32'h0;
        fwd_data = {32'h12345678, 32'hDEADBEEF}; fwd_valid = 2'b11; sel = 4'h0;
        fwd_data_s = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        fwd_valid_s = 3'b111; sel_s = 6'h0;
        tick(); tick();
        n_checks++; if (operand !== 64'h0) $display("FAIL reset_operand: got %h want 0", operand); else n_pass++;
        n_checks++; if (saved !== 2'b00) $display("FAIL reset_saved: got %b want 00", saved); else n_pass++;
        n_checks++; if (hazard_cnt !== 16'h0) $display("FAIL reset_cnt: got %h want 0", hazard_cnt); else n_pass++;
        n_checks++; if (hazard_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", hazard_stall); else n_pass++;
        n_checks++; if (muxed !== 64'h00000022_00000011) $display("FAIL reset_muxed: got %h want 22_11", muxed); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_fwd_imm();
        sel = {2'd1, 2'd2}; imm = 32'h10; fwd_valid = 2'b11;
        #1;
        n_checks++; if (hazard_stall !== 1'b0) $display("FAIL fwd_imm_stall: got %b want 0", hazard_stall); else n_pass++;
        tick();
        n_checks++; if (operand[31:0] !== 32'hDEADBEEF) $display("FAIL fwd_imm_op0: got %h want deadbeef", operand[31:0]); else n_pass++;
        n_checks++; if (operand[63:32] !== 32'h10) $display("FAIL fwd_imm_op1: got %h want 10", operand[63:32]); else n_pass++;
    endtask

    task automatic test_imm_mask();
        rf_data = {32'h22, 32'h5}; imm = 32'h7; sel = {2'd1, 2'd1};
        sel_s = {3'd0, 3'd5};
        #1;
        n_checks++; if (muxed[31:0] !== 32'h5) $display("FAIL imm_reject_op0: got %h want 5", muxed[31:0]); else n_pass++;
        n_checks++; if (muxed[63:32] !== 32'h7) $display("FAIL imm_accept_op1: got %h want 7", muxed[63:32]); else n_pass++;
        n_checks++; if (muxed_s[31:0] !== 32'h5) $display("FAIL sel_out_of_range: got %h want 5", muxed_s[31:0]); else n_pass++;
        sel_s = {3'd0, 3'd4};
        #1;
        n_checks++; if (muxed_s[31:0] !== 32'hCCCC0003) $display("FAIL sel_fwd2: got %h want cccc0003", muxed_s[31:0]); else n_pass++;
        sel_s = 6'h0;
    endtask

    task automatic test_saved();
        sel = 4'h0; id_freeze = 1'b1; rf_data = {32'h22, 32'hA};
        tick();
        n_checks++; if (operand[31:0] !== 32'hA) $display("FAIL saved_capture: got %h want a", operand[31:0]); else n_pass++;
        n_checks++; if (saved !== 2'b11) $display("FAIL saved_set: got %b want 11", saved); else n_pass++;
        rf_data = {32'h22, 32'hB};
        tick();
        n_checks++; if (operand[31:0] !== 32'hA) $display("FAIL saved_hold: got %h want a", operand[31:0]); else n_pass++;
        id_freeze = 1'b0;
        tick();
        n_checks++; if (saved !== 2'b00) $display("FAIL saved_clear: got %b want 00", saved); else n_pass++;
        n_checks++; if (operand[31:0] !== 32'hA) $display("FAIL saved_release_hold: got %h want a", operand[31:0]); else n_pass++;
        tick();
        n_checks++; if (operand[31:0] !== 32'hB) $display("FAIL saved_resume: got %h want b", operand[31:0]); else n_pass++;
    endtask

    task automatic test_hazard();
        rf_data = {32'h22, 32'hC}; sel = {2'd3, 2'd0}; fwd_valid = 2'b01;
        #1;
        n_checks++; if (hazard_stall !== 1'b1) $display("FAIL hazard_raise: got %b want 1", hazard_stall); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (operand !== {32'h22, 32'hB}) $display("FAIL hazard_hold: got %h want 22_b", operand); else n_pass++;
        n_checks++; if (hazard_cnt !== 16'd3) $display("FAIL hazard_cnt3: got %0d want 3", hazard_cnt); else n_pass++;
        fwd_valid = 2'b11;
        #1;
        n_checks++; if (hazard_stall !== 1'b0) $display("FAIL hazard_drop: got %b want 0", hazard_stall); else n_pass++;
        tick();
        n_checks++; if (operand !== {32'h12345678, 32'hC}) $display("FAIL hazard_resume: got %h want 12345678_c", operand); else n_pass++;
        n_checks++; if (hazard_cnt !== 16'd3) $display("FAIL hazard_cnt_stop: got %0d want 3", hazard_cnt); else n_pass++;
    endtask

    task automatic test_ex_freeze_sat();
        ex_freeze = 1'b1; fwd_valid = 2'b01; rf_data = {32'h22, 32'hD};
        #1;
        n_checks++; if (hazard_stall !== 1'b0) $display("FAIL exf_mask_stall: got %b want 0", hazard_stall); else n_pass++;
        tick(); tick();
        n_checks++; if (hazard_cnt !== 16'd3) $display("FAIL exf_cnt_hold: got %0d want 3", hazard_cnt); else n_pass++;
        n_checks++; if (operand !== {32'h12345678, 32'hC}) $display("FAIL exf_op_hold: got %h want 12345678_c", operand); else n_pass++;
        ex_freeze = 1'b0; fwd_valid = 2'b11; sel = 4'h0;
        sel_s = {3'd0, 3'd3}; fwd_valid_s = 3'b101;
        #1;
        n_checks++; if (hazard_stall_s !== 1'b1) $display("FAIL sat_stall: got %b want 1", hazard_stall_s); else n_pass++;
        for (int i = 0; i < 20; i++) tick();
        n_checks++; if (hazard_cnt_s !== 4'hF) $display("FAIL sat_cnt: got %0d want 15", hazard_cnt_s); else n_pass++;
        n_checks++; if (hazard_cnt !== 16'd3) $display("FAIL sat_main_cnt: got %0d want 3", hazard_cnt); else n_pass++;
        sel_s = 6'h0; fwd_valid_s = 3'b111;
    endtask

    task automatic test_flush_rst();
        id_freeze = 1'b1; sel = 4'h0; fwd_valid = 2'b11;
        tick();
        n_checks++; if (saved !== 2'b11) $display("FAIL fr_saved_set: got %b want 11", saved); else n_pass++;
        sel = {2'd3, 2'd0}; fwd_valid = 2'b01;
        tick();
        n_checks++; if (hazard_cnt !== 16'd4) $display("FAIL fr_cnt4: got %0d want 4", hazard_cnt); else n_pass++;
        rst = 1'b1; flush = 1'b1;
        tick();
        n_checks++; if (operand !== 64'h0) $display("FAIL fr_rst_op: got %h want 0", operand); else n_pass++;
        n_checks++; if (saved !== 2'b00) $display("FAIL fr_rst_saved: got %b want 00", saved); else n_pass++;
        n_checks++; if (hazard_cnt !== 16'd0) $display("FAIL fr_rst_cnt: got %0d want 0", hazard_cnt); else n_pass++;
        n_checks++; if (hazard_cnt_s !== 4'd0) $display("FAIL fr_rst_cnt_s: got %0d want 0", hazard_cnt_s); else n_pass++;
        rst = 1'b0; flush = 1'b0;
        tick(); tick();
        n_checks++; if (hazard_cnt !== 16'd2) $display("FAIL fr_cnt2: got %0d want 2", hazard_cnt); else n_pass++;
        fwd_valid = 2'b11; id_freeze = 1'b0; rf_data = {32'h22, 32'h33};
        tick();
        n_checks++; if (operand !== {32'h12345678, 32'h33}) $display("FAIL fr_capture: got %h want 12345678_33", operand); else n_pass++;
        fwd_valid = 2'b01; flush = 1'b1;
        tick();
        n_checks++; if (operand !== 64'h0) $display("FAIL flush_op: got %h want 0", operand); else n_pass++;
        n_checks++; if (hazard_cnt !== 16'd3) $display("FAIL flush_cnt_inc: got %0d want 3", hazard_cnt); else n_pass++;
        flush = 1'b0; fwd_valid = 2'b11;
        tick();
        n_checks++; if (hazard_cnt !== 16'd3) $display("FAIL flush_cnt_keep: got %0d want 3", hazard_cnt); else n_pass++;
        n_checks++; if (operand !== {32'h12345678, 32'h33}) $display("FAIL flush_recapture: got %h want 12345678_33", operand); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fwd_imm();
        test_imm_mask();
        test_saved();
        test_hazard();
        test_ex_freeze_sat();
        test_flush_rst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/or1200_operandmux_gen.md
Name: or1200_operandmux_gen

Overview:
Parametrised operand selection and capture stage between ID and EX. It handles NUM_OPS register-file read operands. Each operand is selected from its register-file port, a shared sign-extended immediate, or one of NUM_FWD forwarding stages (EX, WB, and deeper stages). Compared with the fixed two-operand mux, it adds per-source forwarding valid qualification, a load-use hazard stall request, a pipeline flush, and a saturating hazard-cycle counter.

Parameters:
WIDTH, 32, operand data width in bits
NUM_OPS, 2, number of operand channels (1..4)
NUM_FWD, 2, number of forwarding sources (1..6); source 0 = EX, source 1 = WB, higher = later stages
IMM_MASK, 2'b10, bit i set = operand i may select the immediate
SEL_W, $clog2(NUM_FWD+2), width of each per-operand select field
CNT_W, 16, hazard counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
id_freeze  in  1  ID stage frozen
ex_freeze  in  1  EX stage frozen
flush  in  1  pipeline flush; clears captured operands and saved flags
rf_data  in  NUM_OPS*WIDTH  register-file read data; operand i = slice i
imm  in  WIDTH  sign-extended immediate
fwd_data  in  NUM_FWD*WIDTH  forwarding data; source k = slice k
fwd_valid  in  NUM_FWD  forwarding source k holds final result this cycle
sel  in  NUM_OPS*SEL_W  per-operand select
muxed  out  NUM_OPS*WIDTH  combinational selected value per operand
operand  out  NUM_OPS*WIDTH  registered operand per channel, to EX
saved  out  NUM_OPS  per-operand saved flag
hazard_stall  out  1  combinational stall request to the freeze logic
hazard_cnt  out  CNT_W  saturating count of hazard cycles

Behaviour:
- Select encoding, per operand i:
  - 0 selects rf_data[i].
  - 1 selects imm when IMM_MASK[i] is set; otherwise rf_data[i].
  - 2+k selects fwd_data[k] for k < NUM_FWD.
  - Any other code selects rf_data[i].
- muxed[i] is purely combinational and has zero latency.
- fwd_hit[i] = sel[i] is in 2..NUM_FWD+1 and fwd_valid[k] is low.
- hazard_stall = OR over i of fwd_hit[i], gated by !ex_freeze. It is combinational.
- Capture per operand i, evaluated in priority order each clk edge:
  1. rst: operand = 0, saved = 0, hazard_cnt = 0.
  2. flush: operand = 0, saved = 0. hazard_cnt holds.
  3. !ex_freeze && hazard_stall: operand and saved hold for all channels, so they stay coherent.
  4. !ex_freeze && id_freeze && !saved[i]: operand <= muxed[i], saved[i] <= 1.
  5. !ex_freeze && !saved[i]: operand <= muxed[i].
  6. !ex_freeze && !id_freeze: saved[i] <= 0. Operand holds.
  7. Otherwise everything holds.
- Capture latency: operand reflects muxed one cycle after a qualifying edge.
- A saved operand is not overwritten while id_freeze stays high. The first unfrozen cycle clears saved without capturing; capture resumes on the following cycle.
- hazard_cnt increments on every edge where hazard_stall=1 and no rst. It saturates at all-ones and never wraps. flush does not clear it.
- Simultaneous events:
  - rst dominates flush; flush dominates hazard.
  - ex_freeze high masks both hazard_stall and capture.
  - Several operands hitting different invalid sources still raise a single hazard_stall.
- Reset mid-operation: all state is cleared within the same cycle. No partial capture survives.
- After reset, every output is 0; muxed follows its inputs.

Decomposition:
- Package or1200_opmux_pkg holds:
  - select code constants: SEL_RF=0, SEL_IMM=1, SEL_FWD_BASE=2
  - a function that returns the forward index from a select code
  - a function for the SEL_W computation
- Sub-module or1200_opmux_chan: one operand's select mux plus its capture/saved register. It takes the global hazard hold as an input. The top level instantiates it NUM_OPS times with a generate loop and owns the hazard OR and the counter.

Test Plan:
1. Default params, no freeze, sel0=2, sel1=1, fwd_valid=2'b11, fwd_data[0]=32'hDEADBEEF, imm=32'h00000010 -> next cycle operand0=DEADBEEF, operand1=00000010, hazard_stall=0.
2. sel0=1 with IMM_MASK=2'b10, rf_data[0]=32'h5, imm=32'h7 -> muxed0=5, meaning the immediate is rejected on operand 0; sel0=5 (out of range) -> muxed0=5.
3. id_freeze=1, ex_freeze=0, muxed0=32'hA -> operand0=A, saved0=1. Next cycle change rf to 32'hB: operand0 stays A. Drop id_freeze: saved0=0 at the next edge, then operand0=B one edge later.
4. sel1=3, fwd_valid=2'b01 -> hazard_stall=1, operands hold for 3 cycles, hazard_cnt=3. Raise fwd_valid[1] -> stall drops, operand1=fwd_data[1] the next cycle.
5. Hazard active with ex_freeze=1 -> hazard_stall=0 and hazard_cnt unchanged. With CNT_W=4, force 20 hazard cycles -> hazard_cnt=15.
6. Assert flush and rst together mid-hazard with saved=2'b11 -> next cycle all outputs 0. flush alone -> hazard_cnt retained.
